// File: rtl/btn_press_classifier.sv
// btn_press_classifier: turns a debounced button level into press-start,
// short-press, long-press and (optionally) auto-repeat events. Events are
// handed to control logic through a one-entry valid/ready event register;
// short/long press counters wrap freely.
//
// Optional feature: define REPEAT_EN to enable auto-repeat events (code 11)
// every REPEAT_CYCLES sampled-high cycles while a long press is held.
//
// Handshake: an event is transferred on any rising edge where
// event_valid_o && event_ready_i. Once event_valid_o is asserted, it stays
// asserted with a stable event_code_o until that transfer happens. A new event
// posted on the transfer edge replaces the old one. A new event posted while
// the old one is still waiting is dropped, and overrun_o is set (sticky).
`timescale 1ns/1ps

module btn_press_classifier #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 25_000_000,
  parameter int CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             db_btn_i,
  output logic             press_o,
  output logic             held_o,
  output logic             event_valid_o,
  output logic [1:0]       event_code_o,
  input  logic             event_ready_i,
  output logic             overrun_o,
  output logic [CNT_W-1:0] short_cnt_o,
  output logic [CNT_W-1:0] long_cnt_o
);

  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);

  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_LONG   = 2'b10;
`ifdef REPEAT_EN
  localparam logic [1:0] CODE_REPEAT = 2'b11;
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES);
`endif

  // Elaboration-time guard on parameter ranges.
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("btn_press_classifier: LONG_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("btn_press_classifier: REPEAT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    LONG     = 2'd3
  } state_t;

  state_t              state_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [HOLD_W-1:0]   hold_inc;
  logic                post_valid;
  logic [1:0]          post_code;
`ifdef REPEAT_EN
  logic [REP_W-1:0]    rep_cnt_q;
  logic [REP_W-1:0]    rep_inc;
`endif

  // Classification decision for the current edge: which event (if any) posts.
  always_comb begin
    post_valid = 1'b0;
    post_code  = 2'b00;
    hold_inc   = hold_cnt_q + 1'b1;
`ifdef REPEAT_EN
    rep_inc    = rep_cnt_q + 1'b1;
`endif
    case (state_q)
      PRESSED: begin
        if (db_btn_i) begin
          if (hold_inc == HOLD_LAST) begin
            post_valid = 1'b1;
            post_code  = CODE_LONG;
          end
        end else begin
          post_valid = 1'b1;
          post_code  = CODE_SHORT;
        end
      end
`ifdef REPEAT_EN
      LONG: begin
        if (db_btn_i && (rep_inc == REP_LAST)) begin
          post_valid = 1'b1;
          post_code  = CODE_REPEAT;
        end
      end
`endif
      default: ;
    endcase
  end

  // Press FSM with registered press/held outputs and the press counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= WAIT_REL;
      hold_cnt_q  <= '0;
      press_o     <= 1'b0;
      held_o      <= 1'b0;
      short_cnt_o <= '0;
      long_cnt_o  <= '0;
`ifdef REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      press_o <= 1'b0;
      case (state_q)
        // A button still held through reset must be released before it counts.
        WAIT_REL: begin
          if (!db_btn_i) state_q <= IDLE;
        end
        IDLE: begin
          if (db_btn_i) begin
            state_q    <= PRESSED;
            hold_cnt_q <= HOLD_W'(1);
            press_o    <= 1'b1;
            held_o     <= 1'b1;
          end
        end
        PRESSED: begin
          if (db_btn_i) begin
            hold_cnt_q <= hold_inc;
            if (hold_inc == HOLD_LAST) begin
              state_q    <= LONG;
              long_cnt_o <= long_cnt_o + 1'b1;
`ifdef REPEAT_EN
              rep_cnt_q  <= '0;
`endif
            end
          end else begin
            state_q     <= IDLE;
            held_o      <= 1'b0;
            hold_cnt_q  <= '0;
            short_cnt_o <= short_cnt_o + 1'b1;
          end
        end
        LONG: begin
          if (!db_btn_i) begin
            state_q    <= IDLE;
            held_o     <= 1'b0;
            hold_cnt_q <= '0;
`ifdef REPEAT_EN
            rep_cnt_q  <= '0;
`endif
          end
`ifdef REPEAT_EN
          else if (rep_inc == REP_LAST) begin
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_inc;
          end
`endif
        end
        default: state_q <= WAIT_REL;
      endcase
    end
  end

  // One-entry event register: load on post when empty or draining, else drop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      event_valid_o <= 1'b0;
      event_code_o  <= 2'b00;
      overrun_o     <= 1'b0;
    end else if (post_valid) begin
      if (!event_valid_o || event_ready_i) begin
        event_valid_o <= 1'b1;
        event_code_o  <= post_code;
      end else begin
        overrun_o <= 1'b1;
      end
    end else if (event_valid_o && event_ready_i) begin
      event_valid_o <= 1'b0;
      event_code_o  <= 2'b00;
    end
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed testbench for btn_press_classifier (LONG_CYCLES=8, REPEAT_CYCLES=4).
// Status word layout: {press, held, valid, code[1:0], overrun}.
`timescale 1ns/1ps

module tb_btn_press_classifier;

  localparam int LONG_CYCLES   = 8;
  localparam int REPEAT_CYCLES = 4;
  localparam int CNT_W         = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             db_btn;
  logic             press;
  logic             held;
  logic             event_valid;
  logic [1:0]       event_code;
  logic             event_ready;
  logic             overrun;
  logic [CNT_W-1:0] short_cnt;
  logic [CNT_W-1:0] long_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wire [5:0] status = {press, held, event_valid, event_code, overrun};

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    rst         = 1'b1;
    db_btn      = 1'b0;
    event_ready = 1'b0;
  end

  btn_press_classifier #(
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .db_btn_i     (db_btn),
    .press_o      (press),
    .held_o       (held),
    .event_valid_o(event_valid),
    .event_code_o (event_code),
    .event_ready_i(event_ready),
    .overrun_o    (overrun),
    .short_cnt_o  (short_cnt),
    .long_cnt_o   (long_cnt)
  );

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; db_btn = 1'b0; event_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (status !== 6'b000000) begin
      n_fail++; $display("FAIL reset_status: got %b want %b", status, 6'b000000);
    end
    n_checks++;
    if ({short_cnt, long_cnt} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_counters: got %h want %h", {short_cnt, long_cnt}, 16'h0000);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b000000) begin
      n_fail++; $display("FAIL reset_release_status: got %b want %b", status, 6'b000000);
    end
  endtask

  task automatic test_short();
    event_ready = 1'b1;
    db_btn = 1'b1;
    tick();
    n_checks++;
    if (status !== 6'b110000) begin
      n_fail++; $display("FAIL short_press_pulse: got %b want %b", status, 6'b110000);
    end
    tick();
    n_checks++;
    if (status !== 6'b010000) begin
      n_fail++; $display("FAIL short_press_one_cycle: got %b want %b", status, 6'b010000);
    end
    tick();
    db_btn = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b001010) begin
      n_fail++; $display("FAIL short_event: got %b want %b", status, 6'b001010);
    end
    n_checks++;
    if (short_cnt !== 8'd1) begin
      n_fail++; $display("FAIL short_cnt: got %0d want %0d", short_cnt, 1);
    end
    tick();
    n_checks++;
    if (status !== 6'b000000) begin
      n_fail++; $display("FAIL short_event_drain: got %b want %b", status, 6'b000000);
    end
  endtask

  task automatic test_long();
    logic [5:0] exp;
    event_ready = 1'b1;
    db_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp = {(i == 1), 1'b1, 3'b000, 1'b0};
      if (i == 8) exp[3:1] = 3'b110;
`ifdef REPEAT_EN
      if (i > 8 && (i % 4) == 0) exp[3:1] = 3'b111;
`endif
      n_checks++;
      if (status !== exp) begin
        n_fail++; $display("FAIL long_hold cycle %0d: got %b want %b", i, status, exp);
      end
      if (i == 8) begin
        n_checks++;
        if (long_cnt !== 8'd1) begin
          n_fail++; $display("FAIL long_cnt_at_classify: got %0d want %0d", long_cnt, 1);
        end
      end
    end
    db_btn = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b000000) begin
      n_fail++; $display("FAIL long_release: got %b want %b", status, 6'b000000);
    end
    n_checks++;
    if ({short_cnt, long_cnt} !== {8'd1, 8'd1}) begin
      n_fail++; $display("FAIL long_counters: got %h want %h", {short_cnt, long_cnt}, {8'd1, 8'd1});
    end
  endtask

  task automatic test_overrun();
    event_ready = 1'b0;
    db_btn = 1'b1;
    repeat (3) tick();
    db_btn = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b001010) begin
      n_fail++; $display("FAIL overrun_first_event: got %b want %b", status, 6'b001010);
    end
    tick();
    db_btn = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (status !== 6'b011010) begin
      n_fail++; $display("FAIL overrun_waiting: got %b want %b", status, 6'b011010);
    end
    db_btn = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b001011) begin
      n_fail++; $display("FAIL overrun_drop: got %b want %b", status, 6'b001011);
    end
    n_checks++;
    if (short_cnt !== 8'd3) begin
      n_fail++; $display("FAIL overrun_short_cnt: got %0d want %0d", short_cnt, 3);
    end
    event_ready = 1'b1;
    tick();
    n_checks++;
    if (status !== 6'b000001) begin
      n_fail++; $display("FAIL overrun_drain_sticky: got %b want %b", status, 6'b000001);
    end
  endtask

  task automatic test_reset_mid_press();
    event_ready = 1'b1;
    db_btn = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (status !== 6'b010001) begin
      n_fail++; $display("FAIL midreset_before: got %b want %b", status, 6'b010001);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (status !== 6'b000000) begin
      n_fail++; $display("FAIL midreset_status: got %b want %b", status, 6'b000000);
    end
    n_checks++;
    if ({short_cnt, long_cnt} !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_counters: got %h want %h", {short_cnt, long_cnt}, 16'h0000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (status !== 6'b000000) begin
        n_fail++; $display("FAIL midreset_still_held %0d: got %b want %b", i, status, 6'b000000);
      end
    end
    db_btn = 1'b0;
    tick();
    db_btn = 1'b1;
    tick();
    n_checks++;
    if (status !== 6'b110000) begin
      n_fail++; $display("FAIL midreset_new_press: got %b want %b", status, 6'b110000);
    end
    db_btn = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b001010 || short_cnt !== 8'd1) begin
      n_fail++; $display("FAIL midreset_short: got %b/%0d want %b/%0d", status, short_cnt, 6'b001010, 1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    event_ready = 1'b0;
    db_btn = 1'b1;
    repeat (3) tick();
    db_btn = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b001010 || short_cnt !== 8'd2) begin
      n_fail++; $display("FAIL b2b_first: got %b/%0d want %b/%0d", status, short_cnt, 6'b001010, 2);
    end
    tick();
    db_btn = 1'b1;
    repeat (3) tick();
    event_ready = 1'b1;
    db_btn = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b001010 || short_cnt !== 8'd3) begin
      n_fail++; $display("FAIL b2b_reload: got %b/%0d want %b/%0d", status, short_cnt, 6'b001010, 3);
    end
    tick();
    n_checks++;
    if (status !== 6'b000000) begin
      n_fail++; $display("FAIL b2b_drain: got %b want %b", status, 6'b000000);
    end
  endtask

  task automatic test_boundary();
    event_ready = 1'b1;
    db_btn = 1'b1;
    repeat (7) tick();
    n_checks++;
    if (status !== 6'b010000) begin
      n_fail++; $display("FAIL boundary_7_held: got %b want %b", status, 6'b010000);
    end
    db_btn = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b001010 || {short_cnt, long_cnt} !== {8'd4, 8'd0}) begin
      n_fail++; $display("FAIL boundary_7_short: got %b/%h want %b/%h", status, {short_cnt, long_cnt}, 6'b001010, {8'd4, 8'd0});
    end
    tick();
    db_btn = 1'b1;
    repeat (7) tick();
    n_checks++;
    if (status !== 6'b010000) begin
      n_fail++; $display("FAIL boundary_8_pre: got %b want %b", status, 6'b010000);
    end
    tick();
    n_checks++;
    if (status !== 6'b011100 || {short_cnt, long_cnt} !== {8'd4, 8'd1}) begin
      n_fail++; $display("FAIL boundary_8_long: got %b/%h want %b/%h", status, {short_cnt, long_cnt}, 6'b011100, {8'd4, 8'd1});
    end
    db_btn = 1'b0;
    tick();
    n_checks++;
    if (status !== 6'b000000) begin
      n_fail++; $display("FAIL boundary_8_release: got %b want %b", status, 6'b000000);
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_short();
    test_long();
    test_overrun();
    test_reset_mid_press();
    test_back_to_back();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stalled simulation
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
